// File: rtl/grf_wb_ctrl.sv
// grf_wb_ctrl: write-back controller for the grf write port (WE/A3/WD).
// Two producers share the port: the single-cycle ALU/load path, which is
// never stalled and always wins, and the multi-cycle MDU, whose results
// queue in a small circular FIFO until the ALU leaves the port idle.
// A 32-bit pending scoreboard marks registers with an MDU result in flight,
// so decode can stall readers of those registers.
//
// Optional feature macro: GRF_WB_BYPASS_EN
//   When defined, an MDU result offered while the FIFO is empty and the ALU
//   is idle goes straight to the grf outputs one cycle later, and the FIFO
//   is not written. When undefined, every MDU result passes through the FIFO.
module grf_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_alu_we,
  input  logic [4:0]                   i_alu_a3,
  input  logic [DW-1:0]                i_alu_wd,
  input  logic                         i_mdu_valid,
  output logic                         o_mdu_ready,
  input  logic [4:0]                   i_mdu_a3,
  input  logic [DW-1:0]                i_mdu_wd,
  input  logic                         i_claim_valid,
  input  logic [4:0]                   i_claim_a3,
  output logic                         o_grf_we,
  output logic [4:0]                   o_grf_a3,
  output logic [DW-1:0]                o_grf_wd,
  output logic [31:0]                  o_pend_mask,
  output logic [$clog2(DEPTH):0]       o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    r_fifo_a3 [DEPTH];
  logic [DW-1:0] r_fifo_wd [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;

  logic          r_grf_we;
  logic [4:0]    r_grf_a3;
  logic [DW-1:0] r_grf_wd;
  logic [31:0]   r_pend;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_bypass;
  logic          w_pop;
  logic          w_fifo_wr;
  logic [4:0]    w_head_a3;
  logic [DW-1:0] w_head_wd;
  logic          w_mdu_wb;
  logic [4:0]    w_mdu_wb_a3;
  logic [31:0]   w_pend_next;

  // FIFO status, handshake and arbitration decisions for this cycle
  always_comb begin
    w_full    = (r_count == FULL_CNT);
    w_empty   = (r_count == '0);
    w_push    = i_mdu_valid & ~w_full;
`ifdef GRF_WB_BYPASS_EN
    w_bypass  = w_push & w_empty & ~i_alu_we;
`else
    w_bypass  = 1'b0;
`endif
    // The ALU owns the port whenever it writes; the FIFO only drains in gaps.
    w_pop     = ~i_alu_we & ~w_empty;
    w_fifo_wr = w_push & ~w_bypass;
    w_head_a3 = r_fifo_a3[r_rp];
    w_head_wd = r_fifo_wd[r_rp];
  end

  // Scoreboard next value: MDU write-back clears, a new claim sets and wins
  always_comb begin
    w_mdu_wb    = 1'b0;
    w_mdu_wb_a3 = 5'd0;
    if (!i_alu_we) begin
      if (w_pop) begin
        w_mdu_wb    = 1'b1;
        w_mdu_wb_a3 = w_head_a3;
      end else if (w_bypass) begin
        w_mdu_wb    = 1'b1;
        w_mdu_wb_a3 = i_mdu_a3;
      end
    end
    w_pend_next = r_pend;
    // r0 is never marked pending, so clearing bit 0 on a $0 write is harmless.
    if (w_mdu_wb) w_pend_next[w_mdu_wb_a3] = 1'b0;
    if (i_claim_valid && (i_claim_a3 != 5'd0)) w_pend_next[i_claim_a3] = 1'b1;
  end

  // FIFO storage; not reset because a reset empties the queue via the pointers
  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_fifo_a3[r_wp] <= i_mdu_a3;
      r_fifo_wd[r_wp] <= i_mdu_wd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_fifo_wr) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_fifo_wr) - CW'(w_pop);
    end
  end

  // Registered grf write port; a3=0 entries consume their slot without writing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grf_we <= 1'b0;
      r_grf_a3 <= 5'd0;
      r_grf_wd <= '0;
    end else if (i_alu_we) begin
      r_grf_we <= (i_alu_a3 != 5'd0);
      r_grf_a3 <= i_alu_a3;
      r_grf_wd <= i_alu_wd;
    end else if (w_pop) begin
      r_grf_we <= (w_head_a3 != 5'd0);
      r_grf_a3 <= w_head_a3;
      r_grf_wd <= w_head_wd;
    end else if (w_bypass) begin
      r_grf_we <= (i_mdu_a3 != 5'd0);
      r_grf_a3 <= i_mdu_a3;
      r_grf_wd <= i_mdu_wd;
    end else begin
      r_grf_we <= 1'b0;
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= w_pend_next;
  end

  assign o_mdu_ready  = ~w_full;
  assign o_grf_we     = r_grf_we;
  assign o_grf_a3     = r_grf_a3;
  assign o_grf_wd     = r_grf_wd;
  assign o_pend_mask  = r_pend;
  assign o_fifo_count = r_count;

endmodule
